// File: rtl/image_geom_pkg.sv
// Geometry helpers shared by the gather and scatter image translators:
// delay-depth calculation, pointer width and the coordinate type.
package image_geom_pkg;

  localparam int GEOM_COORD_W = 10;

  typedef logic [GEOM_COORD_W-1:0] coord_t;

  // A gather shift by (sx, sy) needs the pixel sy lines plus sx pixels back.
  function automatic int calc_delay_depth(input int width, input int shift_x, input int shift_y);
    return shift_y * width + shift_x;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/translate_delay_ram.sv
// Single-clock circular delay store: read-before-write with registered read
// data, storage deliberately left without reset.
module translate_delay_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int ADDR_W     = 1
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q      <= mem[addr_i];
      mem[addr_i]  <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/image_translate_gather.sv
// Streaming gather translator: each output raster position takes the input
// pixel SHIFT_Y lines and SHIFT_X pixels earlier. Border fill: TRANSLATE_BORDER_FILL_EN.
module image_translate_gather
  import image_geom_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int SHIFT_X    = 50,
  parameter int SHIFT_Y    = 50,
  parameter int FILL_VALUE = 0,
  parameter int COORD_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  sof_in,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic [COORD_W-1:0]    x_out,
  output logic [COORD_W-1:0]    y_out,
  output logic                  valid_out,
  output logic                  border_out
);

  localparam int Depth = calc_delay_depth(IMG_WIDTH, SHIFT_X, SHIFT_Y);
  localparam int PtrW  = ptr_width(Depth);

  if (Depth < 1) begin : gDepthCheck
    $error("image_translate_gather: SHIFT_X = SHIFT_Y = 0 gives a zero-depth delay");
  end
  if (SHIFT_X >= IMG_WIDTH || SHIFT_Y >= IMG_HEIGHT) begin : gShiftCheck
    $error("image_translate_gather: shift must be smaller than the image");
  end
  if (FILL_VALUE < 0 || longint'(FILL_VALUE) > ((64'd1 << DATA_WIDTH) - 64'd1)) begin : gFillCheck
    $error("image_translate_gather: FILL_VALUE does not fit DATA_WIDTH");
  end

  logic [COORD_W-1:0]    xCnt_q, xCnt_d, yCnt_q, yCnt_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [COORD_W-1:0]    curX, curY;
  logic [PtrW-1:0]       curPtr;
  logic                  curBorder;

  logic                  s1Valid_q, s1Border_q;
  logic [COORD_W-1:0]    s1X_q, s1Y_q;
  logic [DATA_WIDTH-1:0] ramRdata;

  logic                  validOut_q, validOut_d, borderOut_q, borderOut_d;
  logic [DATA_WIDTH-1:0] pixelOut_q, pixelOut_d;
  logic [COORD_W-1:0]    xOut_q, yOut_q;

  // A qualified sof restarts the raster and the delay pointer on this very beat.
  assign curX      = (valid_in && sof_in) ? '0 : xCnt_q;
  assign curY      = (valid_in && sof_in) ? '0 : yCnt_q;
  assign curPtr    = (valid_in && sof_in) ? '0 : ptr_q;
  assign curBorder = (curX < COORD_W'(SHIFT_X)) || (curY < COORD_W'(SHIFT_Y));

  always_comb begin
    xCnt_d = xCnt_q;
    yCnt_d = yCnt_q;
    ptr_d  = ptr_q;
    if (valid_in) begin
      if (curX == COORD_W'(IMG_WIDTH - 1)) begin
        xCnt_d = '0;
        yCnt_d = (curY == COORD_W'(IMG_HEIGHT - 1)) ? '0 : curY + COORD_W'(1);
      end else begin
        xCnt_d = curX + COORD_W'(1);
        yCnt_d = curY;
      end
      if (curX == COORD_W'(IMG_WIDTH - 1) && curY == COORD_W'(IMG_HEIGHT - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = (curPtr == PtrW'(Depth - 1)) ? '0 : curPtr + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xCnt_q     <= '0;
      yCnt_q     <= '0;
      ptr_q      <= '0;
      s1Valid_q  <= 1'b0;
      s1Border_q <= 1'b0;
      s1X_q      <= '0;
      s1Y_q      <= '0;
    end else begin
      xCnt_q     <= xCnt_d;
      yCnt_q     <= yCnt_d;
      ptr_q      <= ptr_d;
      s1Valid_q  <= valid_in;
      s1Border_q <= curBorder;
      s1X_q      <= curX;
      s1Y_q      <= curY;
    end
  end

  translate_delay_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (Depth),
    .ADDR_W    (PtrW)
  ) uDelayRam (
    .clk    (clk),
    .en_i   (valid_in),
    .addr_i (curPtr),
    .wdata_i(pixel_in),
    .rdata_o(ramRdata)
  );

  always_comb begin
`ifdef TRANSLATE_BORDER_FILL_EN
    validOut_d  = s1Valid_q;
    borderOut_d = s1Valid_q & s1Border_q;
    pixelOut_d  = s1Border_q ? DATA_WIDTH'(FILL_VALUE) : ramRdata;
`else
    validOut_d  = s1Valid_q & ~s1Border_q;
    borderOut_d = 1'b0;
    pixelOut_d  = ramRdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validOut_q  <= 1'b0;
      borderOut_q <= 1'b0;
      pixelOut_q  <= '0;
      xOut_q      <= '0;
      yOut_q      <= '0;
    end else begin
      validOut_q  <= validOut_d;
      borderOut_q <= borderOut_d;
      pixelOut_q  <= pixelOut_d;
      xOut_q      <= s1X_q;
      yOut_q      <= s1Y_q;
    end
  end

  assign valid_out  = validOut_q;
  assign border_out = borderOut_q;
  assign pixel_out  = pixelOut_q;
  assign x_out      = xOut_q;
  assign y_out      = yOut_q;

endmodule

// File: tb/tb_image_translate_gather.sv
// Directed bench for image_translate_gather on an 8x4 image shifted by (2,1).
module tb_image_translate_gather;

  localparam int DW    = 8;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int SX    = 2;
  localparam int SY    = 1;
  localparam int FILL  = 165;
  localparam int CW    = 10;
  localparam int D     = 10;
  localparam int FRAME = W * H;
`ifdef TRANSLATE_BORDER_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid_in = 1'b0;
  logic          sof_in = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic [DW-1:0] pixel_out;
  logic [CW-1:0] x_out, y_out;
  logic          valid_out, border_out;

  image_translate_gather #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SHIFT_X(SX),
    .SHIFT_Y(SY), .FILL_VALUE(FILL), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in),
    .pixel_in(pixel_in), .pixel_out(pixel_out), .x_out(x_out), .y_out(y_out),
    .valid_out(valid_out), .border_out(border_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int pix;
    int border;
    int cyc;
  } outBeat_t;

  outBeat_t outQ[$];

  // Every emitted beat is logged mid-cycle with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst_n && valid_out)
      outQ.push_back('{int'(x_out), int'(y_out), int'(pixel_out), int'(border_out), cyc});
  end

  int checks = 0;
  int failures = 0;
  int beatPix[512];
  int beatIdx[512];
  int beatBase[512];
  int beatEdge[512];
  int nIn = 0;
  int curIdx = 0;
  int curBase = 0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one beat, sampled on the next rising edge; the bench tracks its raster index.
  task automatic applyStimulus(input int pix, input bit sof);
    int idx;
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    sof_in   = sof;
    pixel_in = DW'(pix);
    idx = sof ? 0 : curIdx;
    if (idx == 0) curBase = nIn;
    beatPix[nIn]  = pix;
    beatIdx[nIn]  = idx;
    beatBase[nIn] = curBase;
    beatEdge[nIn] = cyc + 1;
    curIdx = (idx + 1) % FRAME;
    nIn++;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      sof_in   = 1'b0;
    end
  endtask

  // Pops the beats expected from inputs gFrom..gTo and checks each one.
  task automatic checkOutput(input string tag, input int gFrom, input int gTo);
    outBeat_t o;
    int idx, x, y, expPix;
    bit brd;
    for (int g = gFrom; g <= gTo; g++) begin
      idx = beatIdx[g];
      x   = idx % W;
      y   = idx / W;
      brd = (x < SX) || (y < SY);
      if (brd && !FILL_EN) continue;
      if (outQ.size() == 0) begin
        checkVal($sformatf("%s_missing_g%0d", tag, g), 0, 1);
        return;
      end
      o = outQ.pop_front();
      expPix = brd ? FILL : beatPix[beatBase[g] + idx - D];
      checkVal($sformatf("%s_x_g%0d", tag, g), o.x, x);
      checkVal($sformatf("%s_y_g%0d", tag, g), o.y, y);
      checkVal($sformatf("%s_pix_g%0d", tag, g), o.pix, expPix);
      checkVal($sformatf("%s_brd_g%0d", tag, g), o.border, int'(brd));
      checkVal($sformatf("%s_lat_g%0d", tag, g), o.cyc, beatEdge[g] + 1);
    end
  endtask

  function automatic int findPix(input int x, input int y);
    foreach (outQ[i]) if (outQ[i].x == x && outQ[i].y == y) return outQ[i].pix;
    return -1;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_valid"}, int'(valid_out), 0);
    checkVal({tag, "_pix"}, int'(pixel_out), 0);
    checkVal({tag, "_x"}, int'(x_out), 0);
    checkVal({tag, "_y"}, int'(y_out), 0);
    checkVal({tag, "_brd"}, int'(border_out), 0);
  endtask

  int g0;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame with sof on the first pixel.
    g0 = nIn;
    for (int n = 0; n < FRAME; n++) applyStimulus(n, n == 0);
    idleCycles(4);
    checkVal("t1_count", outQ.size(), FILL_EN ? 32 : 18);
    checkVal("t1_x3y1", findPix(3, 1), 1);
    checkVal("t1_x7y3", findPix(7, 3), 21);
    if (FILL_EN) begin
      checkVal("t1_x2y1", findPix(2, 1), 0);
      checkVal("t1_x1y2_fill", findPix(1, 2), FILL);
    end else if (outQ.size() > 0) begin
      checkVal("t1_first_x", outQ[0].x, 2);
      checkVal("t1_first_y", outQ[0].y, 1);
      checkVal("t1_first_pix", outQ[0].pix, 0);
      checkVal("t1_last_pix", outQ[outQ.size()-1].pix, 21);
    end
    checkOutput("t1", g0, nIn - 1);
    checkVal("t1_extra", outQ.size(), 0);

    // Same frame with random gaps between beats.
    g0 = nIn;
    for (int n = 0; n < FRAME; n++) begin
      applyStimulus(n, n == 0);
      if ($urandom_range(0, 1) == 1) idleCycles(1);
    end
    idleCycles(4);
    checkVal("t2_count", outQ.size(), FILL_EN ? 32 : 18);
    checkOutput("t2", g0, nIn - 1);
    checkVal("t2_extra", outQ.size(), 0);

    // Two back-to-back frames; the second relies on the implicit wrap.
    g0 = nIn;
    for (int n = 0; n < 2 * FRAME; n++) applyStimulus(n % FRAME, n == 0);
    idleCycles(4);
    checkOutput("t3a", g0, g0 + FRAME - 1);
    checkVal("t3_f2_x3y1", findPix(3, 1), 1);
    checkVal("t3_f2_x2y1", findPix(2, 1), 0);
    checkOutput("t3b", g0 + FRAME, nIn - 1);
    checkVal("t3_extra", outQ.size(), 0);

    // sof arrives on raster index 13 and restarts the frame.
    g0 = nIn;
    for (int n = 0; n < 13 + FRAME; n++) applyStimulus(n, n == 0 || n == 13);
    idleCycles(4);
    checkOutput("t4old", g0, g0 + 12);
    if (FILL_EN && outQ.size() > 0) begin
      checkVal("t4_sof_x", outQ[0].x, 0);
      checkVal("t4_sof_y", outQ[0].y, 0);
      checkVal("t4_sof_brd", outQ[0].border, 1);
    end
    checkVal("t4_new_x2y1", findPix(2, 1), 13);
    checkOutput("t4new", g0 + 13, nIn - 1);
    checkVal("t4_extra", outQ.size(), 0);

    // Reset pulse mid-frame with a beat still in flight.
    for (int n = 0; n < 22; n++) applyStimulus(n, n == 0);
    @(posedge clk);
    #2;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkResetOutputs("t5rst");
    outQ.delete();
    curIdx = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    idleCycles(4);
    checkVal("t5_dropped", outQ.size(), 0);
    g0 = nIn;
    for (int n = 0; n < FRAME; n++) applyStimulus(100 + n, 1'b0);
    idleCycles(4);
    if (FILL_EN && outQ.size() > 0) begin
      checkVal("t5_first_x", outQ[0].x, 0);
      checkVal("t5_first_y", outQ[0].y, 0);
    end
    checkVal("t5_x2y1", findPix(2, 1), 100);
    checkOutput("t5", g0, nIn - 1);
    checkVal("t5_extra", outQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
